// File: rtl/rw_mode_ctrl_pkg.sv
// rw_mode_ctrl_pkg: mode encoding and controller state type shared by the mode controller
package rw_mode_ctrl_pkg;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    typedef enum logic [1:0] {RD, RD2WR, WR, WR2RD} rw_state_t;
endpackage

// File: rtl/rw_mode_ctrl_if.sv
// rw_mode_ctrl_if: scheduler-facing bus of the read/write mode controller; RW_MODE_STATS_EN adds switch counters
interface rw_mode_ctrl_if #(
    parameter int BANK_NUM = 16,
    parameter int WR_BITS  = 3,
    parameter int TOT_BITS = 7
);
    logic [BANK_NUM-1:0]              rd_empty;
    logic [BANK_NUM-1:0][WR_BITS-1:0] wr_num;
    logic                             mode;
    logic                             mode_valid;
    logic                             switch_pulse;
    logic [TOT_BITS-1:0]              wr_total;
`ifdef RW_MODE_STATS_EN
    logic [15:0]                      sw_cnt;
    logic [15:0]                      starve_sw_cnt;
    modport master (output rd_empty, wr_num, input mode, mode_valid, switch_pulse, wr_total, sw_cnt, starve_sw_cnt);
    modport slave  (input rd_empty, wr_num, output mode, mode_valid, switch_pulse, wr_total, sw_cnt, starve_sw_cnt);
`else
    modport master (output rd_empty, wr_num, input mode, mode_valid, switch_pulse, wr_total);
    modport slave  (input rd_empty, wr_num, output mode, mode_valid, switch_pulse, wr_total);
`endif
endinterface

// File: rtl/rw_mode_ctrl_wr_total_sum.sv
// wr_total_sum: balanced adder tree over per-bank pending write counts with a registered total
module wr_total_sum #(
    parameter int BANK_NUM = 16,
    parameter int WR_BITS  = 3,
    parameter int TOT_BITS = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BANK_NUM-1:0][WR_BITS-1:0] wr_num,
    output logic [TOT_BITS-1:0]              wr_total_q
);
    localparam int P = 1 << $clog2(BANK_NUM);
    logic [TOT_BITS-1:0] node [1:2*P-1];
    // heap-ordered tree: leaves at P..2P-1 (unused leaves zero), root at node[1]
    always_comb begin
        for (int i = 0; i < BANK_NUM; i++) node[P+i] = TOT_BITS'(wr_num[i]);
        for (int i = BANK_NUM; i < P; i++) node[P+i] = '0;
        for (int i = P - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    end
    // register the total so all mode decisions see a stable, one-cycle-old value
    always_ff @(posedge clk) begin
        if (!rst_n) wr_total_q <= '0;
        else wr_total_q <= node[1];
    end
endmodule

// File: rtl/rw_mode_ctrl.sv
// rw_mode_ctrl: read/write mode arbiter for the bank schedulers; RW_MODE_STATS_EN adds switch counters
module rw_mode_ctrl
    import rw_mode_ctrl_pkg::*;
#(
    parameter int BANK_NUM     = 16,
    parameter int WR_FIFO_SIZE = 2,
    parameter int WR_FIFO_NUM  = 3,
    parameter int HI_WM        = 48,
    parameter int LO_WM        = 8,
    parameter int MIN_DWELL    = 16,
    parameter int TURN_CYC     = 4,
    parameter int STARVE_LIMIT = 256
) (
    input logic           clk,
    input logic           rst_n,
    rw_mode_ctrl_if.slave bus
);
    localparam int WR_BITS  = $clog2(WR_FIFO_SIZE * WR_FIFO_NUM + 1);
    localparam int TOT_BITS = $clog2(BANK_NUM * WR_FIFO_SIZE * WR_FIFO_NUM + 1);
    localparam int DW       = $clog2(MIN_DWELL + 1);
    localparam int SW       = $clog2(STARVE_LIMIT + 1);

    if (!(LO_WM < HI_WM && HI_WM <= BANK_NUM * WR_FIFO_SIZE * WR_FIFO_NUM)) begin : g_bad_wm
        $error("rw_mode_ctrl: watermarks must satisfy LO_WM < HI_WM <= total write capacity");
    end
    if (MIN_DWELL < 1) begin : g_bad_dwell
        $error("rw_mode_ctrl: MIN_DWELL must be at least 1");
    end
    if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn
        $error("rw_mode_ctrl: TURN_CYC must be in 1..255");
    end

    logic [TOT_BITS-1:0] wr_total_q;
    logic                rd_pend_q;
    rw_state_t           state;
    logic                mode_q;
    logic                mode_valid_q;
    logic                switch_q;
    logic [DW-1:0]       dwell;
    logic [SW-1:0]       starve;
    logic [7:0]          tcnt;
    logic                in_rd;
    logic                in_wr;
    logic                has_wr;
    logic                dwell_ok;
    logic                starved;
    logic                rd_a;
    logic                rd_b;
    logic                wr_a;
    logic                wr_b;
    logic                go;
    logic                go_b;
    logic                other_pend;

    wr_total_sum #(.BANK_NUM(BANK_NUM), .WR_BITS(WR_BITS), .TOT_BITS(TOT_BITS)) u_sum (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_num     (bus.wr_num),
        .wr_total_q (wr_total_q)
    );

    // exit rules evaluated only on registered occupancy; rule (a) of each mode pre-empts (b)
    always_comb begin
        in_rd      = state == RD;
        in_wr      = state == WR;
        has_wr     = wr_total_q != '0;
        dwell_ok   = dwell >= DW'(MIN_DWELL);
        starved    = starve >= SW'(STARVE_LIMIT);
        rd_a       = wr_total_q >= TOT_BITS'(HI_WM);
        rd_b       = starved && has_wr;
        wr_a       = !has_wr && rd_pend_q;
        wr_b       = starved && rd_pend_q && !rd_a;
        go         = in_rd ? (rd_a || rd_b || (!rd_pend_q && has_wr && dwell_ok))
                   : in_wr && (wr_a || wr_b || (wr_total_q <= TOT_BITS'(LO_WM) && rd_pend_q && dwell_ok));
        go_b       = in_rd ? (!rd_a && rd_b) : (!wr_a && wr_b);
        other_pend = in_rd ? has_wr : rd_pend_q;
    end

    // any bank with reads queued, registered alongside the write total
    always_ff @(posedge clk) begin
        if (!rst_n) rd_pend_q <= 1'b0;
        else rd_pend_q <= ~&bus.rd_empty;
    end

    // mode FSM: a switch flips mode at once, then holds mode_valid low for TURN_CYC cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RD;
            mode_q       <= READ;
            mode_valid_q <= 1'b1;
            switch_q     <= 1'b0;
            dwell        <= '0;
            starve       <= '0;
            tcnt         <= '0;
        end else if (go) begin
            state        <= in_rd ? RD2WR : WR2RD;
            mode_q       <= in_rd ? WRITE : READ;
            mode_valid_q <= 1'b0;
            switch_q     <= 1'b1;
            dwell        <= '0;
            starve       <= '0;
            tcnt         <= '0;
        end else if (in_rd || in_wr) begin
            switch_q     <= 1'b0;
            dwell        <= dwell + DW'(!(&dwell));
            starve       <= starve + SW'(other_pend && !(&starve));
        end else begin
            switch_q     <= 1'b0;
            tcnt         <= tcnt + 8'd1;
            if (tcnt == 8'(TURN_CYC - 1)) begin
                state        <= state == RD2WR ? WR : RD;
                mode_valid_q <= 1'b1;
            end
        end
    end

    assign bus.mode         = mode_q;
    assign bus.mode_valid   = mode_valid_q;
    assign bus.switch_pulse = switch_q;
    assign bus.wr_total     = wr_total_q;

`ifdef RW_MODE_STATS_EN
    logic [15:0] sw_cnt_q;
    logic [15:0] starve_sw_cnt_q;
    // saturating tallies of all switches and of starvation-forced switches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_cnt_q        <= '0;
            starve_sw_cnt_q <= '0;
        end else if (go) begin
            sw_cnt_q        <= sw_cnt_q + 16'(!(&sw_cnt_q));
            starve_sw_cnt_q <= starve_sw_cnt_q + 16'(go_b && !(&starve_sw_cnt_q));
        end
    end
    assign bus.sw_cnt        = sw_cnt_q;
    assign bus.starve_sw_cnt = starve_sw_cnt_q;
`endif
endmodule
